gf2_matvec: RTL and testbench

GF2_MATVEC -- requirements
Module: gf2_matvec

---
 rtl/gf2_matvec.sv | 121 ++++++++++++
 tb/tb_gf2_matvec.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/gf2_matvec.sv
// GF(2) matrix-vector product y = A*x (^ e) with A held in an on-chip ROM.
// P rows are evaluated per cycle; the whole result appears M/P+1 cycles after accept.

module gf2_matvec_lane #(
    parameter int N = 128
) (
    input  logic [N-1:0] row,
    input  logic [N-1:0] x,
    input  logic         e,
    input  logic         add_e,
    output logic         y
);
    assign y = (^(row & x)) ^ (e & add_e);
endmodule

module gf2_matvec #(
    parameter int M             = 256,
    parameter int N             = 128,
    parameter int P             = 1,
    parameter     MEM_INIT_FILE = ""
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] x_in,
    input  logic [M-1:0] e_in,
    input  logic         add_e,
    input  logic         req_valid,
    output logic         req_ready,
    output logic         busy,
    output logic [M-1:0] y_out,
    output logic         res_valid,
    input  logic         res_ready
);
    localparam int W  = M / P;
    localparam int KW = $clog2(W + 1);
    localparam int AW = (W > 1) ? $clog2(W) : 1;
    localparam logic [KW-1:0] K_END  = KW'(W);
    localparam logic [AW-1:0] A_LAST = AW'(W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [P*N-1:0] rom [W];
    logic [P*N-1:0] rom_q;
    logic [KW-1:0]  k;
    logic [AW-1:0]  rom_addr, rd_idx;
    logic           rd_vld;
    logic [N-1:0]   x_lat;
    logic [M-1:0]   e_lat, y;
    logic           ae_lat;
    logic [P-1:0]   lane_y, lane_e;
    logic           accept, last_word;
    int             base;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign busy      = (state == RUN);
    assign res_valid = (state == DONE);
    assign y_out     = y;
    assign last_word = rd_vld && (rd_idx == A_LAST);
    // Address parks on the last word once the counter has run past it.
    assign rom_addr  = (k < K_END) ? k[AW-1:0] : A_LAST;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last_word) state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) rom_q <= rom[rom_addr];

    always_comb begin
        base   = int'(rd_idx) * P;
        lane_e = '0;
        for (int p = 0; p < P; p++) lane_e[p] = e_lat[base + p];
    end

    for (genvar p = 0; p < P; p++) begin : g_lane
        gf2_matvec_lane #(.N(N)) u_lane (
            .row   (rom_q[p*N +: N]),
            .x     (x_lat),
            .e     (lane_e[p]),
            .add_e (ae_lat),
            .y     (lane_y[p])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k      <= '0;
            rd_vld <= 1'b0;
            rd_idx <= '0;
            y      <= '0;
            x_lat  <= '0;
            e_lat  <= '0;
            ae_lat <= 1'b0;
        end else begin
            // rd_vld/rd_idx track which word rom_q holds on the next cycle.
            rd_vld <= (state == RUN) && (k < K_END);
            rd_idx <= rom_addr;
            if (accept) begin
                x_lat  <= x_in;
                e_lat  <= e_in;
                ae_lat <= add_e;
                k      <= '0;
            end else if ((state == RUN) && (k < K_END)) begin
                k <= k + KW'(1);
            end
            if ((state == RUN) && rd_vld) y[base +: P] <= lane_y;
        end
    end
endmodule

// File: tb/tb_gf2_matvec.sv
// Directed bench for gf2_matvec: four 8x8 instances with P = 1, 2, 4, 8.
module tb_gf2_matvec;
    logic clk = 1'b0;
    logic rst;
    logic [7:0] x_in, e_in;
    logic add_e;
    logic [3:0] req_valid, res_ready, req_ready, busy, res_valid;
    logic [3:0][7:0] y_out;
    logic [7:0] rows [4][8];
    int pv [4] = '{1, 2, 4, 8};
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    gf2_matvec #(.M(8), .N(8), .P(1)) u_p1 (.clk(clk), .rst(rst), .x_in(x_in), .e_in(e_in), .add_e(add_e),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .busy(busy[0]), .y_out(y_out[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]));
    gf2_matvec #(.M(8), .N(8), .P(2)) u_p2 (.clk(clk), .rst(rst), .x_in(x_in), .e_in(e_in), .add_e(add_e),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .busy(busy[1]), .y_out(y_out[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]));
    gf2_matvec #(.M(8), .N(8), .P(4)) u_p4 (.clk(clk), .rst(rst), .x_in(x_in), .e_in(e_in), .add_e(add_e),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .busy(busy[2]), .y_out(y_out[2]),
        .res_valid(res_valid[2]), .res_ready(res_ready[2]));
    gf2_matvec #(.M(8), .N(8), .P(8)) u_p8 (.clk(clk), .rst(rst), .x_in(x_in), .e_in(e_in), .add_e(add_e),
        .req_valid(req_valid[3]), .req_ready(req_ready[3]), .busy(busy[3]), .y_out(y_out[3]),
        .res_valid(res_valid[3]), .res_ready(res_ready[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic set_row(input int i, input int r, input logic [7:0] v);
        rows[i][r] = v;
        case (i)
            0:       u_p1.rom[r] = v;
            1:       u_p2.rom[r/2][(r%2)*8 +: 8] = v;
            2:       u_p4.rom[r/4][(r%4)*8 +: 8] = v;
            default: u_p8.rom[0][r*8 +: 8] = v;
        endcase
    endtask

    function automatic logic [7:0] model(input int i, input logic [7:0] x, input logic [7:0] e, input logic ae);
        logic [7:0] r;
        for (int j = 0; j < 8; j++) r[j] = (^(rows[i][j] & x)) ^ (ae & e[j]);
        return r;
    endfunction

    // Issue one request, scramble inputs after accept, wait for the result.
    task automatic run_req(input int i, input logic [7:0] x, input logic [7:0] e, input logic ae,
                           input logic [7:0] exp_y, input string tag);
        int lat;
        @(negedge clk);
        x_in = x; e_in = e; add_e = ae; req_valid[i] = 1'b1;
        chk({tag, ".rdy"}, 32'(req_ready[i]), 1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0; x_in = ~x; e_in = 8'($urandom); add_e = ~ae;
        chk({tag, ".busy"}, 32'(busy[i]), 1);
        lat = 0;
        while (!res_valid[i] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(8 / pv[i] + 1));
        chk({tag, ".y"}, 32'(y_out[i]), 32'(exp_y));
    endtask

    task automatic release_res(input int i, input string tag);
        @(negedge clk); res_ready[i] = 1'b1;
        @(posedge clk); #1; res_ready[i] = 1'b0;
        chk({tag, ".rv0"}, 32'(res_valid[i]), 0);
        chk({tag, ".idle"}, 32'(req_ready[i]), 1);
    endtask

    initial begin
        logic [7:0] x, e;
        logic ae;
        int seen;
        rst = 1'b1; x_in = '0; e_in = '0; add_e = 1'b0; req_valid = '0; res_ready = '0;
        for (int r = 0; r < 8; r++) begin
            set_row(0, r, 8'(1 << r));
            set_row(2, r, 8'hFF);
        end
        @(posedge clk); #1;
        chk("rst.rdy", 32'(req_ready), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.rv", 32'(res_valid), 0);
        chk("rst.y", 32'(y_out[0]), 0);
        rst = 1'b0; #1;
        chk("rst.rdy_after", 32'(req_ready), 'hF);

        run_req(0, 8'hA5, 8'h00, 1'b0, 8'hA5, "id");
        release_res(0, "id");
        run_req(0, 8'hA5, 8'hFF, 1'b1, 8'h5A, "id_e");
        release_res(0, "id_e");
        run_req(2, 8'h07, 8'h00, 1'b0, 8'hFF, "ones7");
        release_res(2, "ones7");
        run_req(2, 8'h03, 8'h00, 1'b0, 8'h00, "ones3");
        release_res(2, "ones3");

        // Result must hold while the consumer stalls, with requests hammering.
        run_req(0, 8'h3C, 8'h00, 1'b0, 8'h3C, "hold");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid[0] = 1'b1; x_in = 8'($urandom); #1;
            chk("hold.y", 32'(y_out[0]), 'h3C);
            chk("hold.rv", 32'(res_valid[0]), 1);
            chk("hold.rdy", 32'(req_ready[0]), 0);
            chk("hold.busy", 32'(busy[0]), 0);
        end
        req_valid[0] = 1'b0;
        release_res(0, "hold");

        // Reset in the fourth RUN cycle aborts the request.
        @(negedge clk);
        x_in = 8'hFF; e_in = '0; add_e = 1'b0; req_valid[0] = 1'b1;
        @(posedge clk); #1; req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("abort.busy", 32'(busy[0]), 0);
        chk("abort.rv", 32'(res_valid[0]), 0);
        chk("abort.y", 32'(y_out[0]), 0);
        rst = 1'b0; #1;
        chk("abort.rdy", 32'(req_ready[0]), 1);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            seen |= int'(res_valid[0]);
        end
        chk("abort.no_rv", 32'(seen), 0);
        run_req(0, 8'h81, 8'h00, 1'b0, 8'h81, "post");
        release_res(0, "post");

        // Random ROMs, back-to-back requests.
        foreach (pv[i]) begin
            if (i == 2) continue;
            for (int r = 0; r < 8; r++) set_row(i, r, 8'($urandom));
            repeat (3) begin
                x = 8'($urandom); e = 8'($urandom); ae = 1'($urandom);
                run_req(i, x, e, ae, model(i, x, e, ae), "rnd");
                release_res(i, "rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
